// File: rtl/time_pkg.sv
// Moduli and value widths shared by the seconds/minutes/hours stages of the
// time-of-day datapath.
package time_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/counter_mod24.sv
// Hours stage: modulo-24 counter.
module counter_mod24
  import time_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_auto,
  input  logic              inc_manual,
  input  logic              dec_manual,
  output logic [HOUR_W-1:0] value,
  output logic              carry_out
);

  counter_modn #(
    .MODULUS (HOUR_MOD),
    .WIDTH   (HOUR_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_auto   (inc_auto),
    .inc_manual (inc_manual),
    .dec_manual (dec_manual),
    .value      (value),
    .carry_out  (carry_out)
  );

endmodule

// File: rtl/counter_mod60.sv
// Seconds/minutes stage: modulo-60 counter.
module counter_mod60
  import time_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_auto,
  input  logic             inc_manual,
  input  logic             dec_manual,
  output logic [SEC_W-1:0] value,
  output logic             carry_out
);

  counter_modn #(
    .MODULUS (SEC_MOD),
    .WIDTH   (SEC_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_auto   (inc_auto),
    .inc_manual (inc_manual),
    .dec_manual (dec_manual),
    .value      (value),
    .carry_out  (carry_out)
  );

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down counter: one step per edge, increment beats decrement,
// and a combinational carry on an auto wrap so that stages chain on one edge.
module counter_modn #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_auto,
  input  logic             inc_manual,
  input  logic             dec_manual,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic             inc;
  logic [WIDTH-1:0] value_nxt;

  // Both increment sources collapse into a single step, so together they count once.
  always_comb begin
    inc       = inc_auto | inc_manual;
    value_nxt = value;
    if (inc) begin
      value_nxt = (value == MAX_V) ? '0 : value + 1'b1;
    end else if (dec_manual) begin
      value_nxt = (value == '0) ? MAX_V : value - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

  // Only the auto strobe ripples; setting the clock by hand never carries.
  assign carry_out = inc_auto & (value == MAX_V);

endmodule

// File: tb/tb_counter_modn.sv
// Bench for counter_modn: a standalone mod-60 instance, a mod-24 wrapper and a
// sec/min/hour chain, checked against a bench-side model through an expected queue.
module tb_counter_modn;
  import time_pkg::*;

  localparam int W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       a60, im60, dm60;
  logic [5:0] v60;
  logic       c60;

  counter_modn #(.MODULUS(60), .WIDTH(6)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_auto   (a60),
    .inc_manual (im60),
    .dec_manual (dm60),
    .value      (v60),
    .carry_out  (c60)
  );

  logic       a24, im24, dm24;
  logic [4:0] v24;
  logic       c24;

  counter_mod24 u_mod24 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_auto   (a24),
    .inc_manual (im24),
    .dec_manual (dm24),
    .value      (v24),
    .carry_out  (c24)
  );

  logic       tick, h_set;
  logic [5:0] s_val, m_val;
  logic [4:0] h_val;
  logic       s_carry, m_carry, h_carry;

  counter_mod60 u_sec (
    .clk (clk), .rst_n (rst_n), .inc_auto (tick), .inc_manual (1'b0), .dec_manual (1'b0),
    .value (s_val), .carry_out (s_carry)
  );
  counter_mod60 u_min (
    .clk (clk), .rst_n (rst_n), .inc_auto (s_carry), .inc_manual (1'b0), .dec_manual (1'b0),
    .value (m_val), .carry_out (m_carry)
  );
  counter_mod24 u_hour (
    .clk (clk), .rst_n (rst_n), .inc_auto (m_carry), .inc_manual (h_set), .dec_manual (1'b0),
    .value (h_val), .carry_out (h_carry)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m60 = 0;
  int m24 = 0;
  int total = 0;
  int carry_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_val(input int cur, input int modulus, input logic inc,
                                  input logic dec);
    if (inc) return (cur == modulus - 1) ? 0 : cur + 1;
    if (dec) return (cur == 0) ? modulus - 1 : cur - 1;
    return cur;
  endfunction

  task automatic pop_check(input string tag, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 0, 1);
    end else begin
      check(tag, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic step60(input logic a, input logic im, input logic dm);
    a60 = a; im60 = im; dm60 = dm;
    #1;
    check("carry60", 32'(c60), 32'(a && m60 == 59));
    if (c60) carry_seen++;
    m60 = next_val(m60, 60, a | im, dm);
    exp_q.push_back(W'(m60));
    @(negedge clk);
    pop_check("value60", W'(v60));
  endtask

  task automatic step24(input logic a, input logic im, input logic dm);
    a24 = a; im24 = im; dm24 = dm;
    #1;
    check("carry24", 32'(c24), 32'(a && m24 == 23));
    m24 = next_val(m24, 24, a | im, dm);
    exp_q.push_back(W'(m24));
    @(negedge clk);
    pop_check("value24", W'(v24));
  endtask

  function automatic logic [W-1:0] hms(input int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  // One pulse, one idle cycle; carries are checked against the model while tick is high.
  task automatic tick_chain();
    tick = 1'b1;
    #1;
    check("s_carry", 32'(s_carry), 32'(total % 60 == 59));
    check("m_carry", 32'(m_carry), 32'(total % 3600 == 3599));
    check("h_carry", 32'(h_carry), 32'(total == 86399));
    total = (total + 1) % 86400;
    exp_q.push_back(hms(total));
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    pop_check("chain_time", {h_val, m_val, s_val});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a60 = 0; im60 = 0; dm60 = 0;
    a24 = 0; im24 = 0; dm24 = 0;
    tick = 0; h_set = 0;

    // Reset held for 4 clocks.
    repeat (4) @(negedge clk);
    check("rst_value60", 32'(v60), 0);
    check("rst_carry60", 32'(c60), 0);
    check("rst_value24", 32'(v24), 0);
    check("rst_chain", 32'({h_val, m_val, s_val}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Count to 37, then drop reset between edges.
    for (int i = 0; i < 37; i++) step60(1'b1, 1'b0, 1'b0);
    check("at37", 32'(v60), 37);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'(v60), 0);
    m60 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step60(1'b1, 1'b0, 1'b0);

    // Wrap behaviour of the mod-60 counter.
    for (int i = 0; i < 57; i++) step60(1'b0, 1'b1, 1'b0);
    step60(1'b1, 1'b0, 1'b0);                 // 58 -> 59, no carry
    step60(1'b1, 1'b0, 1'b0);                 // 59 -> 0, carry
    step60(1'b0, 1'b0, 1'b1);                 // 0 -> 59 by dec
    step60(1'b0, 1'b1, 1'b0);                 // 59 -> 0 by manual inc, no carry
    for (int i = 0; i < 5; i++) step60(1'b0, 1'b1, 1'b0);

    // Simultaneous strobes at 5.
    step60(1'b1, 1'b1, 1'b0);
    step60(1'b0, 1'b0, 1'b1);
    step60(1'b0, 1'b1, 1'b1);
    step60(1'b0, 1'b0, 1'b1);
    step60(1'b1, 1'b0, 1'b1);
    step60(1'b0, 1'b0, 1'b1);
    step60(1'b0, 1'b0, 1'b0);
    check("hold5", 32'(v60), 5);

    // inc_auto held 65 cycles from 0.
    for (int i = 0; i < 5; i++) step60(1'b0, 1'b0, 1'b1);
    carry_seen = 0;
    for (int i = 0; i < 65; i++) step60(1'b1, 1'b0, 1'b0);
    check("held65_value", 32'(v60), 5);
    check("held65_carries", 32'(carry_seen), 1);

    // Random strobes.
    for (int i = 0; i < 200; i++)
      step60(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    a60 = 0; im60 = 0; dm60 = 0;

    // mod-24 wrapper.
    for (int i = 0; i < 23; i++) step24(1'b0, 1'b1, 1'b0);
    step24(1'b1, 1'b0, 1'b0);                 // 23 -> 0 with carry
    step24(1'b0, 1'b0, 1'b1);                 // 0 -> 23
    step24(1'b0, 1'b1, 1'b0);                 // 23 -> 0, manual, no carry
    step24(1'b0, 1'b0, 1'b1);                 // 0 -> 23
    step24(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step24(1'b0, 1'b1, 1'b0);
    step24(1'b0, 1'b0, 1'b1);                 // 10 -> 9
    check("mod24_9", 32'(v24), 9);
    for (int i = 0; i < 40; i++)
      step24(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    a24 = 0; im24 = 0; dm24 = 0;

    // Chain: 3598 seconds, then set hours to 23 by hand, then roll over midnight.
    for (int i = 0; i < 3598; i++) tick_chain();
    check("chain_005958", 32'({h_val, m_val, s_val}), 32'(hms(3598)));
    h_set = 1'b1;
    repeat (23) @(negedge clk);
    h_set = 1'b0;
    total = total + 23 * 3600;
    exp_q.push_back(hms(total));
    @(negedge clk);
    pop_check("chain_235958", {h_val, m_val, s_val});
    tick_chain();
    check("chain_235959", 32'({h_val, m_val, s_val}), 32'({5'd23, 6'd59, 6'd59}));
    tick_chain();
    check("chain_000000", 32'({h_val, m_val, s_val}), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
